// File: rtl/mem_access_unit.sv
// MEM stage for a 5-stage pipeline: issues DRAM requests for loads/stores, stalls the
// front end until the access completes or times out, and drives the MEM/WB registers.
module mem_access_unit #(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  wd_sel_i,
  input  logic        rf_we_i,
  input  logic        dram_we_i,
  input  logic [4:0]  wR_i,
  input  logic [31:0] wD_i,
  input  logic [31:0] alu_c_i,
  input  logic [31:0] rD2_i,
  input  logic [31:0] debug_pc_i,
  input  logic        debug_have_inst_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        stall_o,
  output logic        rf_we_o,
  output logic [4:0]  wR_o,
  output logic [31:0] wD_o,
  output logic [31:0] debug_pc_o,
  output logic        debug_have_inst_o,
  output logic        bus_err_o,
  output logic [1:0]  state_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;

  localparam logic [7:0] WAIT_LAST = 8'(ACK_TIMEOUT - 1);

  // Handshake: mem_req_o stays high from REQ entry until the cycle after mem_ack_i is
  // seen (or the wait budget expires); mem_we_o/addr/wdata are frozen for that whole span.
  state_t      state;
  logic [7:0]  wait_cnt;
  logic [1:0]  lat_wd_sel;
  logic        lat_rf_we;
  logic [4:0]  lat_wr;
  logic [31:0] lat_wd;
  logic [31:0] lat_pc;
  logic [31:0] rdata;
  logic        access_need;

  assign access_need = debug_have_inst_i && (dram_we_i || (rf_we_i && wd_sel_i == 2'b01));
  assign stall_o     = (state == REQ) || (state == IDLE && access_need);
  assign state_o     = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      wait_cnt          <= '0;
      mem_req_o         <= 1'b0;
      mem_we_o          <= 1'b0;
      mem_addr_o        <= '0;
      mem_wdata_o       <= '0;
      rf_we_o           <= 1'b0;
      wR_o              <= '0;
      wD_o              <= '0;
      debug_pc_o        <= '0;
      debug_have_inst_o <= 1'b0;
      bus_err_o         <= 1'b0;
      lat_wd_sel        <= '0;
      lat_rf_we         <= 1'b0;
      lat_wr            <= '0;
      lat_wd            <= '0;
      lat_pc            <= '0;
      rdata             <= '0;
    end else begin
      bus_err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (access_need) begin
            state             <= REQ;
            wait_cnt          <= '0;
            mem_req_o         <= 1'b1;
            mem_we_o          <= dram_we_i;
            mem_addr_o        <= {alu_c_i[31:2], 2'b00};
            mem_wdata_o       <= rD2_i;
            lat_wd_sel        <= wd_sel_i;
            lat_rf_we         <= rf_we_i;
            lat_wr            <= wR_i;
            lat_wd            <= wD_i;
            lat_pc            <= debug_pc_i;
            rf_we_o           <= 1'b0;
            debug_have_inst_o <= 1'b0;
          end else begin
            rf_we_o           <= rf_we_i;
            wR_o              <= wR_i;
            wD_o              <= wD_i;
            debug_pc_o        <= debug_pc_i;
            debug_have_inst_o <= debug_have_inst_i;
          end
        end
        REQ: begin
          rf_we_o           <= 1'b0;
          debug_have_inst_o <= 1'b0;
          // An ack arriving on the last allowed cycle still counts as success.
          if (mem_ack_i) begin
            rdata     <= mem_rdata_i;
            mem_req_o <= 1'b0;
            state     <= DONE;
          end else if (wait_cnt == WAIT_LAST) begin
            rdata     <= 32'hDEAD_BEEF;
            mem_req_o <= 1'b0;
            bus_err_o <= 1'b1;
            state     <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        DONE: begin
          rf_we_o           <= lat_rf_we;
          wR_o              <= lat_wr;
          wD_o              <= (lat_wd_sel == 2'b01) ? rdata : lat_wd;
          debug_pc_o        <= lat_pc;
          debug_have_inst_o <= 1'b1;
          state             <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a default-timeout instance and a short-timeout
// instance share all inputs; vectors cover pass-through, loads, stores, timeout, reset.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  wd_sel_i;
  logic        rf_we_i, dram_we_i, debug_have_inst_i, mem_ack_i;
  logic [4:0]  wR_i;
  logic [31:0] wD_i, alu_c_i, rD2_i, debug_pc_i, mem_rdata_i;

  logic        mem_req_o, mem_we_o, stall_o, rf_we_o, debug_have_inst_o, bus_err_o;
  logic [31:0] mem_addr_o, mem_wdata_o, wD_o, debug_pc_o;
  logic [4:0]  wR_o;
  logic [1:0]  state_o;

  logic        t_req, t_we, t_stall, t_rf_we, t_have, t_err;
  logic [31:0] t_addr, t_wdata, t_wd, t_pc;
  logic [4:0]  t_wr;
  logic [1:0]  t_state;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [31:0] exp_q[$];
  logic [31:0] pc_q[$];

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk(clk), .rst(rst), .wd_sel_i(wd_sel_i), .rf_we_i(rf_we_i), .dram_we_i(dram_we_i),
    .wR_i(wR_i), .wD_i(wD_i), .alu_c_i(alu_c_i), .rD2_i(rD2_i), .debug_pc_i(debug_pc_i),
    .debug_have_inst_i(debug_have_inst_i), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i),
    .mem_rdata_i(mem_rdata_i), .stall_o(stall_o), .rf_we_o(rf_we_o), .wR_o(wR_o),
    .wD_o(wD_o), .debug_pc_o(debug_pc_o), .debug_have_inst_o(debug_have_inst_o),
    .bus_err_o(bus_err_o), .state_o(state_o)
  );

  mem_access_unit #(.ACK_TIMEOUT(3)) dut_t (
    .clk(clk), .rst(rst), .wd_sel_i(wd_sel_i), .rf_we_i(rf_we_i), .dram_we_i(dram_we_i),
    .wR_i(wR_i), .wD_i(wD_i), .alu_c_i(alu_c_i), .rD2_i(rD2_i), .debug_pc_i(debug_pc_i),
    .debug_have_inst_i(debug_have_inst_i), .mem_req_o(t_req), .mem_we_o(t_we),
    .mem_addr_o(t_addr), .mem_wdata_o(t_wdata), .mem_ack_i(mem_ack_i),
    .mem_rdata_i(mem_rdata_i), .stall_o(t_stall), .rf_we_o(t_rf_we), .wR_o(t_wr),
    .wD_o(t_wd), .debug_pc_o(t_pc), .debug_have_inst_o(t_have),
    .bus_err_o(t_err), .state_o(t_state)
  );

  typedef struct {
    logic        have;
    logic        rf_we;
    logic [1:0]  sel;
    logic        dram;
    logic        ack;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic [31:0] pc;
    logic        exp_stall;
    logic        exp_rf_we;
    logic        exp_have;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_inst(input logic have, input logic rf_we, input logic [1:0] sel,
                          input logic dram, input logic [4:0] wr, input logic [31:0] wd,
                          input logic [31:0] addr, input logic [31:0] sd, input logic [31:0] pc);
    debug_have_inst_i = have;
    rf_we_i = rf_we;
    wd_sel_i = sel;
    dram_we_i = dram;
    wR_i = wr;
    wD_i = wd;
    alu_c_i = addr;
    rD2_i = sd;
    debug_pc_i = pc;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem_ack_i = 1'b0;
    mem_rdata_i = '0;
    set_inst(1'b0, 1'b0, 2'b00, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd_vals[2];
    rd_vals[0] = 32'h1111_1111;
    rd_vals[1] = 32'h2222_2222;

    vecs[0] = '{1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 5'd5,  32'h0000_1234, 32'h0000_0100, 1'b0, 1'b1, 1'b1};
    vecs[1] = '{1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 5'd31, 32'hFFFF_FFFF, 32'h0000_0104, 1'b0, 1'b1, 1'b1};
    vecs[2] = '{1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 5'd9,  32'h0000_ABCD, 32'h0000_0108, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 5'd0,  32'h0000_0000, 32'h0000_010C, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 2'b11, 1'b0, 1'b1, 5'd17, 32'h5A5A_0000, 32'h0000_0110, 1'b0, 1'b1, 1'b1};
    vecs[5] = '{1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 5'd2,  32'h0000_0042, 32'h0000_0114, 1'b0, 1'b0, 1'b0};

    // Reset state
    do_reset();
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_req", 32'(mem_req_o), 32'd0);
    check("rst_addr", mem_addr_o, 32'h0);
    check("rst_wd", wD_o, 32'h0);
    check("rst_have", 32'(debug_have_inst_o), 32'd0);
    check("rst_err", 32'(bus_err_o), 32'd0);

    // Non-memory instructions pass straight through in one cycle
    for (int i = 0; i < 6; i++) begin
      set_inst(vecs[i].have, vecs[i].rf_we, vecs[i].sel, vecs[i].dram, vecs[i].wr,
               vecs[i].wd, 32'h0000_0200, 32'h0, vecs[i].pc);
      mem_ack_i = vecs[i].ack;
      #1;
      check($sformatf("v%0d_stall", i), 32'(stall_o), 32'(vecs[i].exp_stall));
      tick();
      check($sformatf("v%0d_req", i), 32'(mem_req_o), 32'd0);
      check($sformatf("v%0d_rf_we", i), 32'(rf_we_o), 32'(vecs[i].exp_rf_we));
      check($sformatf("v%0d_have", i), 32'(debug_have_inst_o), 32'(vecs[i].exp_have));
      check($sformatf("v%0d_wr", i), 32'(wR_o), 32'(vecs[i].wr));
      check($sformatf("v%0d_wd", i), wD_o, vecs[i].wd);
      check($sformatf("v%0d_pc", i), debug_pc_o, vecs[i].pc);
    end
    mem_ack_i = 1'b0;

    // Load with ack in first REQ cycle
    do_reset();
    set_inst(1'b1, 1'b1, 2'b01, 1'b0, 5'd7, 32'h0000_9999, 32'h0000_0103, 32'h0, 32'h0000_0200);
    #1;
    check("ld_stall0", 32'(stall_o), 32'd1);
    tick();
    check("ld_req", 32'(mem_req_o), 32'd1);
    check("ld_addr", mem_addr_o, 32'h0000_0100);
    check("ld_we", 32'(mem_we_o), 32'd0);
    check("ld_stall1", 32'(stall_o), 32'd1);
    check("ld_bubble_have", 32'(debug_have_inst_o), 32'd0);
    check("ld_bubble_rf_we", 32'(rf_we_o), 32'd0);
    mem_ack_i = 1'b1;
    mem_rdata_i = 32'hCAFE_F00D;
    tick();
    mem_ack_i = 1'b0;
    mem_rdata_i = 32'h0;
    check("ld_done_req", 32'(mem_req_o), 32'd0);
    check("ld_done_stall", 32'(stall_o), 32'd0);
    check("ld_done_state", 32'(state_o), 32'd2);
    tick();
    check("ld_wd", wD_o, 32'hCAFE_F00D);
    check("ld_wr", 32'(wR_o), 32'd7);
    check("ld_rf_we", 32'(rf_we_o), 32'd1);
    check("ld_pc", debug_pc_o, 32'h0000_0200);
    check("ld_have", 32'(debug_have_inst_o), 32'd1);

    // Store with ack in the fifth REQ cycle; request fields must stay latched
    do_reset();
    set_inst(1'b1, 1'b0, 2'b00, 1'b1, 5'd4, 32'h0, 32'h0000_0040, 32'hA5A5_A5A5, 32'h0000_0300);
    tick();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("st_req%0d", i), 32'(mem_req_o), 32'd1);
      check($sformatf("st_we%0d", i), 32'(mem_we_o), 32'd1);
      check($sformatf("st_addr%0d", i), mem_addr_o, 32'h0000_0040);
      check($sformatf("st_wdata%0d", i), mem_wdata_o, 32'hA5A5_A5A5);
      check($sformatf("st_stall%0d", i), 32'(stall_o), 32'd1);
      alu_c_i = 32'hFFFF_FFFC;
      rD2_i = 32'h0;
      if (i == 4) mem_ack_i = 1'b1;
      tick();
    end
    mem_ack_i = 1'b0;
    check("st_done_req", 32'(mem_req_o), 32'd0);
    check("st_done_err", 32'(bus_err_o), 32'd0);
    tick();
    check("st_rf_we", 32'(rf_we_o), 32'd0);
    check("st_have", 32'(debug_have_inst_o), 32'd1);
    check("st_pc", debug_pc_o, 32'h0000_0300);

    // Timeout on the short-budget instance
    do_reset();
    set_inst(1'b1, 1'b1, 2'b01, 1'b0, 5'd3, 32'h0, 32'h0000_0080, 32'h0, 32'h0000_0310);
    #1;
    check("to_stall0", 32'(t_stall), 32'd1);
    tick();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("to_req%0d", i), 32'(t_req), 32'd1);
      check($sformatf("to_err%0d", i), 32'(t_err), 32'd0);
      tick();
    end
    check("to_drop_req", 32'(t_req), 32'd0);
    check("to_err_pulse", 32'(t_err), 32'd1);
    check("to_state", 32'(t_state), 32'd2);
    set_inst(1'b0, 1'b0, 2'b00, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    tick();
    check("to_err_clear", 32'(t_err), 32'd0);
    check("to_wd", t_wd, 32'hDEAD_BEEF);
    check("to_rf_we", 32'(t_rf_we), 32'd1);
    check("to_wr", 32'(t_wr), 32'd3);

    // Reset while in REQ, then a late ack
    do_reset();
    set_inst(1'b1, 1'b1, 2'b01, 1'b1, 5'd6, 32'h0000_0055, 32'h0000_0024, 32'h1357_9BDF, 32'h0000_0320);
    tick();
    check("rq_req", 32'(mem_req_o), 32'd1);
    rst = 1'b1;
    tick();
    check("rq_state", 32'(state_o), 32'd0);
    check("rq_req0", 32'(mem_req_o), 32'd0);
    check("rq_we0", 32'(mem_we_o), 32'd0);
    check("rq_addr0", mem_addr_o, 32'h0);
    check("rq_wdata0", mem_wdata_o, 32'h0);
    check("rq_rf_we0", 32'(rf_we_o), 32'd0);
    check("rq_wr0", 32'(wR_o), 32'd0);
    check("rq_pc0", debug_pc_o, 32'h0);
    check("rq_err0", 32'(bus_err_o), 32'd0);
    rst = 1'b0;
    mem_ack_i = 1'b1;
    mem_rdata_i = 32'h0000_0077;
    set_inst(1'b0, 1'b0, 2'b00, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    tick();
    mem_ack_i = 1'b0;
    check("rq_late_state", 32'(state_o), 32'd0);
    check("rq_late_req", 32'(mem_req_o), 32'd0);
    check("rq_late_wd", wD_o, 32'h0);
    check("rq_late_have", 32'(debug_have_inst_o), 32'd0);

    // Back-to-back loads: each gets its own request phase
    do_reset();
    for (int k = 0; k < 2; k++) begin
      set_inst(1'b1, 1'b1, 2'b01, 1'b0, 5'(k + 1), 32'h0, 32'h0000_0010 + 32'(4 * k),
               32'h0, 32'h0000_0400 + 32'(4 * k));
      exp_q.push_back(rd_vals[k]);
      pc_q.push_back(32'h0000_0400 + 32'(4 * k));
      #1;
      check($sformatf("bb%0d_stall", k), 32'(stall_o), 32'd1);
      check($sformatf("bb%0d_req_low", k), 32'(mem_req_o), 32'd0);
      tick();
      check($sformatf("bb%0d_req", k), 32'(mem_req_o), 32'd1);
      check($sformatf("bb%0d_addr", k), mem_addr_o, 32'h0000_0010 + 32'(4 * k));
      mem_ack_i = 1'b1;
      mem_rdata_i = rd_vals[k];
      tick();
      mem_ack_i = 1'b0;
      mem_rdata_i = 32'h0;
      tick();
      check($sformatf("bb%0d_have", k), 32'(debug_have_inst_o), 32'd1);
      if (debug_have_inst_o === 1'b1 && exp_q.size() > 0) begin
        check($sformatf("bb%0d_wd", k), wD_o, exp_q.pop_front());
        check($sformatf("bb%0d_pc", k), debug_pc_o, pc_q.pop_front());
      end
      check($sformatf("bb%0d_wr", k), 32'(wR_o), 32'(k + 1));
    end
    check("bb_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
